glb_cfg_arbiter: RTL
====================

Name: glb_cfg_arbiter

Overview:
- Shares the global-buffer configuration register port between NUM_REQ requesters, e.g. AXI-lite slave (req 0) and JTAG (req 1).
- Arbitrates round-robin with one transaction outstanding at a time.
- Sequences the gated clock enables (wr_clk_en/rd_clk_en) around the one-cycle wr_en/rd_en strobe.
- For reads, waits for rd_data_valid, then returns a response to the granted requester.

Parameters:
- ADDR_WIDTH, 32, config address width.
- DATA_WIDTH, 32, config data width.
- NUM_REQ, 2, number of requesters (>=2).
- RD_TIMEOUT, 255, max WAIT cycles before error (used only with the macro).

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  request accepted (valid&&ready)
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the granted requester
- rsp_rdata  out  DATA_WIDTH  read data, shared bus
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- wr_en, wr_clk_en  out  1  config write strobe and write clock enable
- wr_addr  out  ADDR_WIDTH  config write address
- wr_data  out  DATA_WIDTH  config write data
- rd_en, rd_clk_en  out  1  config read strobe and read clock enable
- rd_addr  out  ADDR_WIDTH  config read address
- rd_data  in  DATA_WIDTH  config read data
- rd_data_valid  in  1  read data valid

Behaviour:
- Reset (reset_n=0 sampled at posedge): state IDLE, rr pointer 0. All outputs 0, including rsp_rdata and rsp_err.
- Reset mid-transaction aborts it. No response is issued and the glb outputs drop to 0 on the next cycle.
- FSM states: IDLE, PRE, ACC, POST, WAIT, RSP.
- IDLE:
  - Grant the lowest index >= pointer (wrapping) with req_valid=1.
  - req_ready[g]=1 combinationally in that cycle only; req_ready is 0 in every other state.
  - Latch write/addr/wdata of g; set pointer = (g+1) mod NUM_REQ; go to PRE.
  - No valid requester: stay in IDLE.
- PRE (1 cycle): wr_clk_en=1 for a write, rd_clk_en=1 for a read. Strobes 0.
- ACC (1 cycle): the matching clk_en=1 plus wr_en=1 (wr_addr, wr_data driven) or rd_en=1 (rd_addr driven).
  - Write goes to POST; read goes to WAIT.
  - A rd_data_valid sampled in ACC is accepted and the FSM goes directly to RSP.
- POST (1 cycle): wr_clk_en=1. Next state RSP.
- WAIT: rd_clk_en=1. On rd_data_valid, capture rd_data into rsp_rdata and go to RSP.
- RSP (1 cycle): rsp_valid[g]=1, rsp_err as computed. Next state IDLE; a new grant is possible the cycle after RSP.
- Write latency: accept at T, wr_en at T+2, rsp_valid at T+4.
- Read latency: rsp_valid one cycle after rd_data_valid is sampled.
- Output hold rules:
  - Address/data outputs are 0 outside ACC.
  - rsp_rdata holds its value until the next read response; writes do not change it.
- rd_data_valid sampled in IDLE/PRE/POST/RSP is ignored.
- Simultaneous valids are resolved by the rr pointer only; no requester waits more than NUM_REQ-1 grants.

Optional Feature:
- Macro: GLB_CFG_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches RD_TIMEOUT without rd_data_valid: go to RSP with rsp_err=1 and rsp_rdata=0.
  - rd_data_valid in the same cycle as the timeout wins (rsp_err=0).
- Undefined: no counter, rsp_err tied to 0, WAIT persists until rd_data_valid.

Decomposition:
- Package glb_cfg_arb_pkg:
  - state enum.
  - default widths taken from the shared AXI_ADDR_WIDTH/AXI_DATA_WIDTH constants.
  - timeout counter width function.
- Sub-module glb_rr_arbiter: combinational round-robin grant (one-hot + index) from req_valid and the pointer.
- FSM, latches and timeout stay in the top module.

Test Plan:
- Write: req0 write addr 0x0000_0104, data 0xDEAD_BEEF, accepted at T.
  - wr_clk_en high T+1..T+3; wr_en high only at T+2 with that addr/data.
  - rsp_valid=01 at T+4, rsp_err=0.
- Read: req1 read addr 0x200; model asserts rd_data_valid 3 cycles after rd_en with 0x1234_5678.
  - rd_clk_en high from PRE until valid; rsp_valid=10 the next cycle; rsp_rdata=0x1234_5678.
- Fairness: both requesters hold valid for 8 transactions from reset.
  - Grants alternate 0,1,0,1…; req_ready pulses never twice in a row to the same requester.
- Timeout (macro on, RD_TIMEOUT=16): read with no rd_data_valid.
  - rsp_err=1, rsp_rdata=0, rsp_valid 17 cycles after the WAIT entry edge.
  - Macro off: no rsp_valid within 1000 cycles.
- Reset mid-WAIT: reset_n=0 for 1 cycle.
  - Next cycle all outputs 0, no rsp_valid.
  - Then both requesters valid → req0 granted first (pointer 0).
- Stray valid: rd_data_valid=1 with rd_data=0xFFFF_FFFF while IDLE.
  - No rsp_valid; rsp_rdata unchanged.

Source files
------------

// File: rtl/glb_cfg_arb_pkg.sv
// rtl/glb_cfg_arb_pkg.sv - shared types, default widths and helpers for the glb config arbiter
package glb_cfg_arb_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ACC,
    ST_POST,
    ST_WAIT,
    ST_RSP
  } state_t;

  // Counter must be able to hold the limit value itself.
  function automatic int timeout_cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/glb_rr_arbiter.sv
// rtl/glb_rr_arbiter.sv - combinational round-robin grant starting at the pointer
module glb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int cand;

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/glb_cfg_arbiter.sv
// rtl/glb_cfg_arbiter.sv - round-robin arbiter sequencing the glb config port
// Optional read timeout enabled by defining GLB_CFG_ARB_TIMEOUT_EN.
module glb_cfg_arbiter
  import glb_cfg_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH,
  parameter int NUM_REQ    = 2,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          wr_en,
  output logic                          wr_clk_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          rd_en,
  output logic                          rd_clk_en,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          rd_data_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                 state, state_next;
  logic [IDX_W-1:0]       ptr, lat_idx;
  logic                   lat_write;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic [DATA_WIDTH-1:0]  lat_wdata;
  logic [NUM_REQ-1:0]     gnt_onehot;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_any;
  logic                   capture_rd;
  logic                   timeout_hit;

  glb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (gnt_onehot),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  // Read data is only meaningful while a read is actually in flight.
  assign capture_rd = rd_data_valid &&
                      ((state == ST_ACC && !lat_write) || state == ST_WAIT);

`ifdef GLB_CFG_ARB_TIMEOUT_EN
  localparam int CNT_W = timeout_cnt_width(RD_TIMEOUT);
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  assign timeout_hit = (state == ST_WAIT) && !rd_data_valid &&
                       (to_cnt == CNT_W'(RD_TIMEOUT));
  assign rsp_err     = (state == ST_RSP) && err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == ST_WAIT) ? to_cnt + CNT_W'(1) : '0;
      if (state == ST_IDLE && gnt_any) err_q <= 1'b0;
      else if (timeout_hit)            err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && gnt_any) begin
        lat_idx   <= gnt_idx;
        lat_write <= req_write[gnt_idx];
        lat_addr  <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        lat_wdata <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        ptr       <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      if (capture_rd)       rsp_rdata <= rd_data;
      else if (timeout_hit) rsp_rdata <= '0;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    wr_en      = 1'b0;
    wr_clk_en  = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_en      = 1'b0;
    rd_clk_en  = 1'b0;
    rd_addr    = '0;
    case (state)
      ST_IDLE: begin
        // Gated by reset so no handshake is advertised while held in reset.
        if (reset_n) req_ready = gnt_onehot;
        if (gnt_any) state_next = ST_PRE;
      end
      ST_PRE: begin
        wr_clk_en  = lat_write;
        rd_clk_en  = !lat_write;
        state_next = ST_ACC;
      end
      ST_ACC: begin
        if (lat_write) begin
          wr_clk_en  = 1'b1;
          wr_en      = 1'b1;
          wr_addr    = lat_addr;
          wr_data    = lat_wdata;
          state_next = ST_POST;
        end else begin
          rd_clk_en  = 1'b1;
          rd_en      = 1'b1;
          rd_addr    = lat_addr;
          state_next = rd_data_valid ? ST_RSP : ST_WAIT;
        end
      end
      ST_POST: begin
        wr_clk_en  = 1'b1;
        state_next = ST_RSP;
      end
      ST_WAIT: begin
        rd_clk_en = 1'b1;
        if (rd_data_valid || timeout_hit) state_next = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid[lat_idx] = 1'b1;
        state_next         = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
